io_seg7_display: RTL and testbench



---
 rtl/io_seg7_display_if.sv | 25 ++
 rtl/io_seg7_display.sv | 154 +++++++++++++++
 tb/tb_io_seg7_display.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/io_seg7_display_if.sv
// Bundle of the three output-port words, the hold control and the six
// active-low 7-segment digit drivers.
interface io_seg7_display_if;
  logic [31:0] port0;
  logic [31:0] port1;
  logic [31:0] port2;
  logic        hold;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;
  logic        valid;

  modport master (
    output port0, port1, port2, hold,
    input  hex0, hex1, hex2, hex3, hex4, hex5, valid
  );

  modport slave (
    input  port0, port1, port2, hold,
    output hex0, hex1, hex2, hex3, hex4, hex5, valid
  );
endinterface

// File: rtl/io_seg7_display.sv
// Shows three 32-bit port words as two-digit decimals on six 7-segment displays,
// using one shared double-dabble engine cycled round-robin over the channels.
module io_seg7_display #(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  io_seg7_display_if.slave    bus_io
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StShift  = 2'd2;
  localparam logic [1:0] StCommit = 2'd3;

  localparam logic [6:0] SegDash  = 7'h3F;
  localparam logic [6:0] SegBlank = 7'h7F;

  logic [1:0]      state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [19:0]     sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [5:0][6:0] hex_q, hex_d;
  logic            valid_q, valid_d;

  logic [31:0]     sel_port;
  logic [3:0]      h4, t4, o4;
  logic [6:0]      tens_seg, ones_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  always_comb begin
    unique case (ch_q)
      2'd0:    sel_port = bus_io.port0;
      2'd1:    sel_port = bus_io.port1;
      default: sel_port = bus_io.port2;
    endcase
  end

  assign h4 = sr_q[19:16];
  assign t4 = sr_q[15:12];
  assign o4 = sr_q[11:8];

  always_comb begin
    if (ovf_q || (h4 != 4'd0)) begin
      tens_seg = SegDash;
      ones_seg = SegDash;
    end else begin
      ones_seg = seg7(o4);
      tens_seg = (LZ_BLANK && (t4 == 4'd0)) ? SegBlank : seg7(t4);
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (!bus_io.hold) state_d = StLoad;
      end
      StLoad: begin
        ovf_d   = |sel_port[31:8];
        sr_d    = {12'd0, sel_port[7:0]};
        cnt_d   = 3'd0;
        state_d = StShift;
      end
      StShift: begin
        sr_d  = dabble_step(sr_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StCommit;
      end
      default: begin
        unique case (ch_q)
          2'd0: begin
            hex_d[1] = tens_seg;
            hex_d[0] = ones_seg;
          end
          2'd1: begin
            hex_d[3] = tens_seg;
            hex_d[2] = ones_seg;
          end
          default: begin
            hex_d[5] = tens_seg;
            hex_d[4] = ones_seg;
            valid_d  = 1'b1;
          end
        endcase
        ch_d    = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= 2'd0;
      sr_q    <= 20'd0;
      cnt_q   <= 3'd0;
      ovf_q   <= 1'b0;
      hex_q   <= {6{SegBlank}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.hex0  = hex_q[0];
  assign bus_io.hex1  = hex_q[1];
  assign bus_io.hex2  = hex_q[2];
  assign bus_io.hex3  = hex_q[3];
  assign bus_io.hex4  = hex_q[4];
  assign bus_io.hex5  = hex_q[5];
  assign bus_io.valid = valid_q;

endmodule

// File: tb/tb_io_seg7_display.sv
// Directed bench for io_seg7_display: two instances (leading-zero blank on/off)
// share one stimulus stream.
module tb_io_seg7_display;

  logic        clock;
  logic        reset;
  logic [31:0] p0, p1, p2;
  logic        hold;
  int          n_cmp;
  int          n_err;

  io_seg7_display_if if_a ();
  io_seg7_display_if if_b ();

  assign if_a.port0 = p0;
  assign if_a.port1 = p1;
  assign if_a.port2 = p2;
  assign if_a.hold  = hold;
  assign if_b.port0 = p0;
  assign if_b.port1 = p1;
  assign if_b.port2 = p2;
  assign if_b.hold  = hold;

  io_seg7_display #(.LZ_BLANK(1'b1)) dut_a (
    .clock  (clock),
    .reset  (reset),
    .bus_io (if_a.slave)
  );

  io_seg7_display #(.LZ_BLANK(1'b0)) dut_b (
    .clock  (clock),
    .reset  (reset),
    .bus_io (if_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    hold  = 1'b0;
    p0    = 32'd37;
    p1    = 32'd5;
    p2    = 32'd99;
    repeat (2) @(negedge clock);
    check("reset_hex0", if_a.hex0, 7'h7F);
    check("reset_valid", {6'd0, if_a.valid}, 7'h00);
    reset = 1'b0;

    // First sweep: channel 0 commits on edge 11, full sweep by edge 33.
    edges(10);
    check("pre_commit_hex0", if_a.hex0, 7'h7F);
    edges(1);
    check("c0_hex1", if_a.hex1, 7'h30);
    check("c0_hex0", if_a.hex0, 7'h78);
    check("c0_valid", {6'd0, if_a.valid}, 7'h00);
    edges(22);
    check("sweep_hex3", if_a.hex3, 7'h7F);
    check("sweep_hex2", if_a.hex2, 7'h12);
    check("sweep_hex5", if_a.hex5, 7'h10);
    check("sweep_hex4", if_a.hex4, 7'h10);
    check("sweep_valid", {6'd0, if_a.valid}, 7'h01);
    check("lz0_hex3", if_b.hex3, 7'h40);
    check("lz0_hex2", if_b.hex2, 7'h12);
    check("lz0_hex1", if_b.hex1, 7'h30);

    // Asynchronous reset in the middle of channel-0 SHIFT.
    edges(5);
    #2 reset = 1'b1;
    #1;
    check("areset_hex0", if_a.hex0, 7'h7F);
    check("areset_hex1", if_a.hex1, 7'h7F);
    check("areset_hex2", if_a.hex2, 7'h7F);
    check("areset_hex3", if_a.hex3, 7'h7F);
    check("areset_hex4", if_a.hex4, 7'h7F);
    check("areset_hex5", if_a.hex5, 7'h7F);
    check("areset_valid", {6'd0, if_a.valid}, 7'h00);
    @(negedge clock);
    reset = 1'b0;
    edges(10);
    check("rst2_pre_hex1", if_a.hex1, 7'h7F);
    edges(1);
    check("rst2_hex1", if_a.hex1, 7'h30);
    check("rst2_hex0", if_a.hex0, 7'h78);
    check("rst2_valid", {6'd0, if_a.valid}, 7'h00);
    edges(22);
    check("rst2_valid_set", {6'd0, if_a.valid}, 7'h01);

    // Overflow cases; each wait of 33 edges keeps the sweep phase aligned.
    p2 = 32'd100;
    edges(33);
    check("ovf100_hex5", if_a.hex5, 7'h3F);
    check("ovf100_hex4", if_a.hex4, 7'h3F);
    check("ovf100_hex1", if_a.hex1, 7'h30);
    check("ovf100_hex3", if_a.hex3, 7'h7F);
    check("ovf100_lz0_hex5", if_b.hex5, 7'h3F);
    p2 = 32'h0000_0105;
    edges(33);
    check("ovf105_hex5", if_a.hex5, 7'h3F);
    check("ovf105_hex4", if_a.hex4, 7'h3F);
    check("ovf105_hex0", if_a.hex0, 7'h78);
    p0 = 32'h0000_0100;
    edges(33);
    check("ovf256_hex1", if_a.hex1, 7'h3F);
    check("ovf256_hex0", if_a.hex0, 7'h3F);
    check("ovf256_hex2", if_a.hex2, 7'h12);
    check("ovf256_hex5", if_a.hex5, 7'h3F);
    p0 = 32'd37;
    p2 = 32'd99;
    edges(33);
    check("restore_hex1", if_a.hex1, 7'h30);
    check("restore_hex0", if_a.hex0, 7'h78);
    check("restore_hex4", if_a.hex4, 7'h10);

    // Hold asserted in IDLE before channel 0 loads.
    hold = 1'b1;
    p0   = 32'd42;
    edges(100);
    check("hold_hex1", if_a.hex1, 7'h30);
    check("hold_hex0", if_a.hex0, 7'h78);
    hold = 1'b0;
    edges(10);
    check("unhold_pre_hex1", if_a.hex1, 7'h30);
    edges(1);
    check("unhold_hex1", if_a.hex1, 7'h19);
    check("unhold_hex0", if_a.hex0, 7'h24);
    edges(22);

    // Input change during SHIFT does not reach the current commit.
    p0 = 32'd37;
    edges(33);
    check("shift_base_hex0", if_a.hex0, 7'h78);
    edges(4);
    p0 = 32'd42;
    edges(7);
    check("shift_old_hex1", if_a.hex1, 7'h30);
    check("shift_old_hex0", if_a.hex0, 7'h78);
    edges(33);
    check("shift_new_hex1", if_a.hex1, 7'h19);
    check("shift_new_hex0", if_a.hex0, 7'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
